// File: rtl/spu_issue_ctrl.sv
// spu_issue_ctrl: dual-issue scheduler between the SPU pair decoder and the
// even/odd execution pipes. It holds one decoded pair, checks structural and
// register hazards against a per-register latency scoreboard, and issues the
// slots in order. A pair is split or stalled when it cannot issue together.
//
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   pair_valid / pair_ready     decoder handshake (pair_ready is combinational)
//   pipe_*, ra_*, rb_*, rt_*    slot 0/1 pipe select (0=even, 1=odd) and register fields
//   rd_a_*, rd_b_*, wr_*        source-used and writes-rt flags
//   lat_*                       result latency 1..7 (0 is treated as 1)
//   flush                       discard the held pair, suppress this cycle's issue
//   ev_*, od_*                  registered issue strobes and fields per pipe
//   struc_hazard                one-cycle pulse when a pair splits on a shared pipe
//   stall_cnt                   saturating count of cycles a deciding slot was held back
module spu_issue_ctrl #(
    parameter int unsigned NREG = 128,
    parameter int unsigned LATW = 3,
    parameter int unsigned CNTW = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            pair_valid,
    output logic            pair_ready,
    input  logic            pipe_0,
    input  logic            pipe_1,
    input  logic [6:0]      ra_0,
    input  logic [6:0]      rb_0,
    input  logic [6:0]      rt_0,
    input  logic [6:0]      ra_1,
    input  logic [6:0]      rb_1,
    input  logic [6:0]      rt_1,
    input  logic            rd_a_0,
    input  logic            rd_b_0,
    input  logic            rd_a_1,
    input  logic            rd_b_1,
    input  logic            wr_0,
    input  logic            wr_1,
    input  logic [LATW-1:0] lat_0,
    input  logic [LATW-1:0] lat_1,
    input  logic            flush,
    output logic            ev_valid,
    output logic            od_valid,
    output logic [6:0]      ev_ra,
    output logic [6:0]      ev_rb,
    output logic [6:0]      ev_rt,
    output logic [6:0]      od_ra,
    output logic [6:0]      od_rb,
    output logic [6:0]      od_rt,
    output logic            ev_wr,
    output logic            od_wr,
    output logic            struc_hazard,
    output logic [CNTW-1:0] stall_cnt
);

    localparam int unsigned RW = 7;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_HOLD2 = 2'd1,
        S_HOLD1 = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // Held pair; latencies are stored already normalised (0 -> 1)
    logic            r_pipe0, r_pipe1;
    logic            r_rda0, r_rdb0, r_rda1, r_rdb1;
    logic            r_wr0, r_wr1;
    logic [RW-1:0]   r_ra0, r_rb0, r_rt0, r_ra1, r_rb1, r_rt1;
    logic [LATW-1:0] r_lat0, r_lat1;

    // Cycles until each register becomes readable
    logic [LATW-1:0] r_sb [NREG];

    logic w_haz0, w_haz1, w_dep, w_waw;
    logic w_iss0, w_iss1, w_full, w_acc;
    logic w_split_struc, w_stall;
    logic w_set0, w_set1;

    // Slot hazards: pending source, or a write that would retire before an older one
    assign w_haz0 = (r_rda0 && (r_sb[r_ra0] != '0)) ||
                    (r_rdb0 && (r_sb[r_rb0] != '0)) ||
                    (r_wr0  && (r_sb[r_rt0] > r_lat0));
    assign w_haz1 = (r_rda1 && (r_sb[r_ra1] != '0)) ||
                    (r_rdb1 && (r_sb[r_rb1] != '0)) ||
                    (r_wr1  && (r_sb[r_rt1] > r_lat1));

    // Intra-pair dependencies the scoreboard cannot see yet
    assign w_dep = r_wr0 && ((r_rda1 && (r_ra1 == r_rt0)) || (r_rdb1 && (r_rb1 == r_rt0)));
    assign w_waw = r_wr0 && r_wr1 && (r_rt0 == r_rt1);

    // Issue decision and next state
    always_comb begin
        w_iss0        = 1'b0;
        w_iss1        = 1'b0;
        w_full        = 1'b0;
        w_split_struc = 1'b0;
        w_stall       = 1'b0;
        w_state_nxt   = r_state;

        case (r_state)
            S_EMPTY: begin
                w_full = 1'b1;
            end
            S_HOLD2: begin
                w_iss0 = !w_haz0;
                w_iss1 = w_iss0 && (r_pipe0 != r_pipe1) && !w_haz1 && !w_dep && !w_waw;
                w_full = w_iss0 && w_iss1;
                // A split is not a stall; only a blocked slot 0 counts here
                w_stall       = !w_iss0;
                w_split_struc = w_iss0 && (r_pipe0 == r_pipe1);
                if (w_iss0 && !w_iss1) begin
                    w_state_nxt = S_HOLD1;
                end
            end
            S_HOLD1: begin
                w_iss1  = !w_haz1;
                w_full  = w_iss1;
                w_stall = !w_iss1;
            end
            default: begin
                w_state_nxt = S_EMPTY;
            end
        endcase

        if (flush) begin
            w_iss0        = 1'b0;
            w_iss1        = 1'b0;
            w_full        = 1'b0;
            w_split_struc = 1'b0;
            w_stall       = 1'b0;
            w_state_nxt   = S_EMPTY;
        end else if (w_full) begin
            w_state_nxt = (pair_valid) ? S_HOLD2 : S_EMPTY;
        end
    end

    assign pair_ready = w_full;
    assign w_acc      = pair_valid && w_full;
    assign w_set0     = w_iss0 && r_wr0;
    assign w_set1     = w_iss1 && r_wr1;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Pair capture
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pipe0 <= 1'b0;
            r_pipe1 <= 1'b0;
            r_rda0  <= 1'b0;
            r_rdb0  <= 1'b0;
            r_rda1  <= 1'b0;
            r_rdb1  <= 1'b0;
            r_wr0   <= 1'b0;
            r_wr1   <= 1'b0;
            r_ra0   <= '0;
            r_rb0   <= '0;
            r_rt0   <= '0;
            r_ra1   <= '0;
            r_rb1   <= '0;
            r_rt1   <= '0;
            r_lat0  <= LATW'(1);
            r_lat1  <= LATW'(1);
        end else if (w_acc) begin
            r_pipe0 <= pipe_0;
            r_pipe1 <= pipe_1;
            r_rda0  <= rd_a_0;
            r_rdb0  <= rd_b_0;
            r_rda1  <= rd_a_1;
            r_rdb1  <= rd_b_1;
            r_wr0   <= wr_0;
            r_wr1   <= wr_1;
            r_ra0   <= ra_0;
            r_rb0   <= rb_0;
            r_rt0   <= rt_0;
            r_ra1   <= ra_1;
            r_rb1   <= rb_1;
            r_rt1   <= rt_1;
            r_lat0  <= (lat_0 == '0) ? LATW'(1) : lat_0;
            r_lat1  <= (lat_1 == '0) ? LATW'(1) : lat_1;
        end
    end

    // Scoreboard: issuing writers load their latency, everything else counts down
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                r_sb[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NREG; i++) begin
                if (w_set0 && (r_rt0 == RW'(i))) begin
                    r_sb[i] <= r_lat0;
                end else if (w_set1 && (r_rt1 == RW'(i))) begin
                    r_sb[i] <= r_lat1;
                end else if (r_sb[i] != '0) begin
                    r_sb[i] <= r_sb[i] - LATW'(1);
                end
            end
        end
    end

    // Issue strobes routed by pipe bit; both slots never target the same pipe together
    always_ff @(posedge clk) begin
        if (reset) begin
            ev_valid     <= 1'b0;
            od_valid     <= 1'b0;
            ev_ra        <= '0;
            ev_rb        <= '0;
            ev_rt        <= '0;
            od_ra        <= '0;
            od_rb        <= '0;
            od_rt        <= '0;
            ev_wr        <= 1'b0;
            od_wr        <= 1'b0;
            struc_hazard <= 1'b0;
            stall_cnt    <= '0;
        end else begin
            ev_valid     <= 1'b0;
            od_valid     <= 1'b0;
            ev_ra        <= '0;
            ev_rb        <= '0;
            ev_rt        <= '0;
            od_ra        <= '0;
            od_rb        <= '0;
            od_rt        <= '0;
            ev_wr        <= 1'b0;
            od_wr        <= 1'b0;
            struc_hazard <= w_split_struc;
            if (w_iss0) begin
                if (r_pipe0) begin
                    od_valid <= 1'b1;
                    od_ra    <= r_ra0;
                    od_rb    <= r_rb0;
                    od_rt    <= r_rt0;
                    od_wr    <= r_wr0;
                end else begin
                    ev_valid <= 1'b1;
                    ev_ra    <= r_ra0;
                    ev_rb    <= r_rb0;
                    ev_rt    <= r_rt0;
                    ev_wr    <= r_wr0;
                end
            end
            if (w_iss1) begin
                if (r_pipe1) begin
                    od_valid <= 1'b1;
                    od_ra    <= r_ra1;
                    od_rb    <= r_rb1;
                    od_rt    <= r_rt1;
                    od_wr    <= r_wr1;
                end else begin
                    ev_valid <= 1'b1;
                    ev_ra    <= r_ra1;
                    ev_rb    <= r_rb1;
                    ev_rt    <= r_rt1;
                    ev_wr    <= r_wr1;
                end
            end
            if (w_stall && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNTW'(1);
            end
        end
    end

endmodule
